// File: rtl/dist_pkg.sv
// Shared types and helpers for the serial N-dimensional distance engine.
package dist_pkg;

  typedef enum logic {
    DIST_MAN   = 1'b0,
    DIST_SQEUC = 1'b1
  } dist_mode_e;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } dist_state_e;

  // Counter width that never collapses to zero bits, even for a single dimension.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dist_term.sv
// Per-dimension distance term: absolute difference, or its square.
module dist_term
  import dist_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  dist_mode_e         mode,
  output logic [2*WIDTH-1:0] term
);

  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] diff_ext;

  always_comb begin
    // Compare first so the subtraction can never wrap.
    diff     = (a >= b) ? (a - b) : (b - a);
    diff_ext = {{WIDTH{1'b0}}, diff};
    term     = (mode == DIST_SQEUC) ? (diff_ext * diff_ext) : diff_ext;
  end

endmodule

// File: rtl/dist_acc_nd.sv
// Serial distance engine: accumulates one dimension per clock, then holds the result for the sorter.
module dist_acc_nd
  import dist_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int DIMS   = 4,
  localparam int DIST_W = 2*WIDTH + $clog2(DIMS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIMS*WIDTH-1:0] a_i,
  input  logic [DIMS*WIDTH-1:0] b_i,
  input  logic                  mode_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  yumi_i,
  output logic [DIST_W-1:0]     dist_o
);

  localparam int IDX_W = clog2_min1(DIMS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIMS - 1);

  dist_state_e           state;
  logic [IDX_W-1:0]      idx;
  logic [DIST_W-1:0]     acc;
  logic [DIST_W-1:0]     dist_q;
  logic [DIMS*WIDTH-1:0] a_q;
  logic [DIMS*WIDTH-1:0] b_q;
  dist_mode_e            mode_q;

  logic [WIDTH-1:0]      a_d;
  logic [WIDTH-1:0]      b_d;
  logic [2*WIDTH-1:0]    term;
  logic [DIST_W-1:0]     acc_next;
  logic                  accept;

  assign ready_o = (state == S_WAIT);
  assign valid_o = (state == S_DONE);
  assign dist_o  = dist_q;
  assign accept  = valid_i && ready_o;

  always_comb begin
    a_d      = a_q[int'(idx)*WIDTH +: WIDTH];
    b_d      = b_q[int'(idx)*WIDTH +: WIDTH];
    acc_next = acc + DIST_W'(term);
  end

  dist_term #(
    .WIDTH (WIDTH)
  ) u_term (
    .a    (a_d),
    .b    (b_d),
    .mode (mode_q),
    .term (term)
  );

  // Operand capture: ports are only sampled on the accept edge.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q    <= a_i;
      b_q    <= b_i;
      mode_q <= dist_mode_e'(mode_i);
    end
  end

  // Control, accumulator and result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_WAIT;
      idx    <= '0;
      acc    <= '0;
      dist_q <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (valid_i) begin
            state <= S_ACCUM;
            idx   <= '0;
            acc   <= '0;
          end
        end
        S_ACCUM: begin
          acc <= acc_next;
          if (idx == IDX_LAST) begin
            dist_q <= acc_next;
            state  <= S_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (yumi_i) state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_acc_nd.sv
// Directed bench for dist_acc_nd: a DIMS=4 instance plus a DIMS=1 regression instance.
module tb_dist_acc_nd;

  logic        clk;
  logic        rst;

  logic [15:0] a_i, b_i;
  logic        mode_i, valid_i, yumi_i;
  logic        ready_o, valid_o;
  logic [9:0]  dist_o;

  logic [3:0]  a1, b1;
  logic        mode1, valid1, yumi1;
  logic        ready1, vo1;
  logic [7:0]  dist1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  dist_acc_nd #(.WIDTH(4), .DIMS(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .a_i     (a_i),
    .b_i     (b_i),
    .mode_i  (mode_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .yumi_i  (yumi_i),
    .dist_o  (dist_o)
  );

  dist_acc_nd #(.WIDTH(4), .DIMS(1)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .a_i     (a1),
    .b_i     (b1),
    .mode_i  (mode1),
    .valid_i (valid1),
    .ready_o (ready1),
    .valid_o (vo1),
    .yumi_i  (yumi1),
    .dist_o  (dist1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pack4(input int d0, input int d1, input int d2, input int d3);
    return {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  // One full transaction on the DIMS=4 unit, consumed right after completion.
  task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic [9:0] exp);
    int n;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL %s_ready_before: got %b want 1", name, ready_o);
    end
    a_i = a; b_i = b; mode_i = m; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 0;
    while (valid_o !== 1'b1 && n < 20) begin
      checks++;
      if (ready_o !== 1'b0) begin
        errors++; $display("FAIL %s_ready_busy: got %b want 0", name, ready_o);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL %s_latency: got %0d edges want 4", name, n);
    end
    checks++;
    if (dist_o !== exp) begin
      errors++; $display("FAIL %s_dist: got %0d want %0d", name, dist_o, exp);
    end
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL %s_release: got ready=%b valid=%b want ready=1 valid=0", name, ready_o, valid_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_i = '0; b_i = '0; mode_i = 1'b0; valid_i = 1'b0; yumi_i = 1'b0;
    a1 = '0; b1 = '0; mode1 = 1'b0; valid1 = 1'b0; yumi1 = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || dist_o !== 10'd0) begin
      errors++; $display("FAIL reset_state: got ready=%b valid=%b dist=%0d want 1 0 0", ready_o, valid_o, dist_o);
    end
    checks++;
    if (ready1 !== 1'b1 || vo1 !== 1'b0 || dist1 !== 8'd0) begin
      errors++; $display("FAIL reset_state_d1: got ready=%b valid=%b dist=%0d want 1 0 0", ready1, vo1, dist1);
    end
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_manhattan();
    run_op("man_basic", pack4(3, 7, 0, 15), pack4(5, 2, 0, 0), 1'b0, 10'd22);
  endtask

  task automatic test_squared();
    run_op("sq_basic", pack4(3, 7, 0, 15), pack4(5, 2, 0, 0), 1'b1, 10'd254);
  endtask

  task automatic test_extremes();
    run_op("sq_max",   16'hFFFF, 16'h0000, 1'b1, 10'd900);
    run_op("man_max",  16'hFFFF, 16'h0000, 1'b0, 10'd60);
    run_op("man_rev",  16'h0000, 16'hFFFF, 1'b0, 10'd60);
    run_op("sq_equal", pack4(5, 9, 1, 12), pack4(5, 9, 1, 12), 1'b1, 10'd0);
    run_op("man_equal", pack4(5, 9, 1, 12), pack4(5, 9, 1, 12), 1'b0, 10'd0);
  endtask

  task automatic test_backpressure();
    int n;
    a_i = pack4(3, 7, 0, 15); b_i = pack4(5, 2, 0, 0); mode_i = 1'b0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    n = 0;
    while (valid_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      a_i = 16'($urandom); b_i = 16'($urandom); mode_i = ~mode_i; valid_i = ~valid_i;
      @(posedge clk); #1;
      checks++;
      if (dist_o !== 10'd22 || ready_o !== 1'b0 || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got dist=%0d ready=%b valid=%b want 22 0 1", i, dist_o, ready_o, valid_o);
      end
    end
    valid_i = 1'b0; yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || dist_o !== 10'd22) begin
      errors++; $display("FAIL bp_release: got ready=%b valid=%b dist=%0d want 1 0 22", ready_o, valid_o, dist_o);
    end
    // yumi with nothing pending must not disturb the idle unit.
    yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || dist_o !== 10'd22) begin
      errors++; $display("FAIL stray_yumi: got ready=%b valid=%b dist=%0d want 1 0 22", ready_o, valid_o, dist_o);
    end
  endtask

  task automatic test_async_reset();
    a_i = 16'hFFFF; b_i = 16'h0000; mode_i = 1'b1; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || dist_o !== 10'd0) begin
      errors++; $display("FAIL async_reset: got ready=%b valid=%b dist=%0d want 1 0 0", ready_o, valid_o, dist_o);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_reset", pack4(3, 7, 0, 15), pack4(5, 2, 0, 0), 1'b1, 10'd254);
  endtask

  task automatic test_back_to_back();
    logic [15:0] av [4];
    logic [15:0] bv [4];
    logic        mv [4];
    logic [9:0]  ev [4];
    int n, last;
    av[0] = pack4(3, 7, 0, 15); bv[0] = pack4(5, 2, 0, 0); mv[0] = 1'b0; ev[0] = 10'd22;
    av[1] = 16'hFFFF;           bv[1] = 16'h0000;          mv[1] = 1'b1; ev[1] = 10'd900;
    av[2] = 16'hFFFF;           bv[2] = 16'h0000;          mv[2] = 1'b0; ev[2] = 10'd60;
    av[3] = pack4(3, 7, 0, 15); bv[3] = pack4(5, 2, 0, 0); mv[3] = 1'b1; ev[3] = 10'd254;
    last = 0;
    a_i = av[0]; b_i = bv[0]; mode_i = mv[0]; valid_i = 1'b1; yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (valid_o !== 1'b1 && n < 30);
      checks++;
      if (dist_o !== ev[k]) begin
        errors++; $display("FAIL b2b_dist_%0d: got %0d want %0d", k, dist_o, ev[k]);
      end
      if (k > 0) begin
        checks++;
        if (cyc - last !== 6) begin
          errors++; $display("FAIL b2b_period_%0d: got %0d cycles want 6", k, cyc - last);
        end
      end
      last = cyc;
      if (k < 3) begin
        a_i = av[k+1]; b_i = bv[k+1]; mode_i = mv[k+1];
      end
    end
    valid_i = 1'b0;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got ready=%b valid=%b want 1 0", ready_o, valid_o);
    end
  endtask

  task automatic test_dims1();
    logic [7:0] exp1 [2];
    exp1[0] = 8'd25;
    exp1[1] = 8'd5;
    for (int k = 0; k < 2; k++) begin
      a1 = 4'd9; b1 = 4'd4; mode1 = (k == 0); valid1 = 1'b1;
      @(posedge clk); #1;
      valid1 = 1'b0;
      checks++;
      if (vo1 !== 1'b0 || ready1 !== 1'b0) begin
        errors++; $display("FAIL d1_accum_%0d: got valid=%b ready=%b want 0 0", k, vo1, ready1);
      end
      @(posedge clk); #1;
      checks++;
      if (vo1 !== 1'b1 || dist1 !== exp1[k]) begin
        errors++; $display("FAIL d1_result_%0d: got valid=%b dist=%0d want 1 %0d", k, vo1, dist1, exp1[k]);
      end
      yumi1 = 1'b1;
      @(posedge clk); #1;
      yumi1 = 1'b0;
      checks++;
      if (ready1 !== 1'b1) begin
        errors++; $display("FAIL d1_release_%0d: got ready=%b want 1", k, ready1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manhattan();
    test_squared();
    test_extremes();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_dims1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
